// File: rtl/bcd_disp_pkg.sv
// Shared constants and the BCD-to-segment mapping for the multiplexed display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Non-BCD codes fall through to a dash so a corrupted counter is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational wrapper around bcd_to_seg so the top can instantiate one
// decoder shared by all four scan slots.
module bcd_seg_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(code);

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed 7-segment driver: snapshots the BCD digits once per
// scan frame, blanks leading zeros and blinks the display while held.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       BTNU,
  input  logic [3:0] en0,
  input  logic [3:0] en1,
  input  logic [3:0] en2,
  input  logic [3:0] en3,
  input  logic [3:0] dp_en,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         sel;
  logic [3:0][3:0]    shadow;
  logic [3:0]         shadow_dp;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;

  logic       tick;
  logic       frame_wrap;
  logic [3:0] lead_zero;
  logic       slot_blank;
  logic [6:0] dec_seg;
  logic [3:0] an_next;

  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign frame_wrap = tick && (sel == 2'd3);

  always_ff @(posedge clk) begin
    if (BTNU) begin
      div_cnt <= '0;
      sel     <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      sel     <= sel + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // The snapshot keeps a counter update mid-frame from tearing the display.
  always_ff @(posedge clk) begin
    if (BTNU) begin
      shadow     <= '0;
      shadow_dp  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (frame_wrap) begin
        shadow    <= {en3, en2, en1, en0};
        shadow_dp <= dp_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (BTNU || !hold) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // A digit is a leading zero only if every more significant digit is zero too.
  assign lead_zero[3] = (shadow[3] == 4'd0);
  assign lead_zero[2] = lead_zero[3] && (shadow[2] == 4'd0);
  assign lead_zero[1] = lead_zero[2] && (shadow[1] == 4'd0);
  assign lead_zero[0] = 1'b0;

  assign slot_blank = blink_off || lead_zero[sel];

  bcd_seg_decoder u_decoder (
    .code (shadow[sel]),
    .seg  (dec_seg)
  );

  always_comb begin
    an_next = 4'b1111;
    if (!slot_blank) an_next[sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (BTNU) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= slot_blank ? SEG_BLANK : dec_seg;
      dp  <= slot_blank ? 1'b1 : ~shadow_dp[sel];
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: a per-cycle reference model built
// from frame/slot arithmetic, a vector table of frames, and corner sequences.
module tb_bcd_scan_display;

  localparam int CLK_DIV      = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       BTNU = 1'b1;
  logic [3:0] en0 = 4'd0, en1 = 4'd0, en2 = 4'd0, en3 = 4'd0;
  logic [3:0] dp_en = 4'd0;
  logic       hold = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int checks = 0;
  int failures = 0;

  bcd_scan_display #(.CLK_DIV(CLK_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk        (clk),
    .BTNU       (BTNU),
    .en0        (en0),
    .en1        (en1),
    .en2        (en2),
    .en3        (en3),
    .dp_en      (dp_en),
    .hold       (hold),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state: cycles since reset release, latched digits, and
  // how many frame wraps have elapsed during the current hold interval.
  int         m_n = 0;
  logic [3:0] m_sh [4];
  logic [3:0] m_dp = 4'd0;
  int         m_held = 0;
  logic [6:0] seg_tab [16];

  typedef struct {
    logic [3:0]  e3, e2, e1, e0;
    logic [3:0]  dpe;
    logic [15:0] an_exp;
    logic [27:0] seg_exp;
    logic [3:0]  dp_exp;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                               input logic [3:0] d0, input logic [3:0] dpe, input logic h);
    en3 = d3; en2 = d2; en1 = d1; en0 = d0; dp_en = dpe; hold = h;
  endtask

  // One clock: predict outputs from the model, advance it, then compare.
  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed, ef;
    int         s;
    bit         blank, wrap, allz;
    wrap = 1'b0;
    if (BTNU) begin
      ea = 4'hF; es = 7'h7F; ed = 1'b1; ef = 1'b0;
    end else begin
      s = (m_n / CLK_DIV) % 4;
      blank = ((m_held / BLINK_FRAMES) % 2) == 1;
      if (s > 0) begin
        allz = 1'b1;
        for (int j = s; j < 4; j++) if (m_sh[j] != 4'd0) allz = 1'b0;
        if (allz) blank = 1'b1;
      end
      ea = 4'hF;
      if (!blank) ea[s] = 1'b0;
      es = blank ? 7'h7F : seg_tab[m_sh[s]];
      ed = blank ? 1'b1 : ~m_dp[s];
      wrap = ((m_n + 1) % FRAME_LEN) == 0;
      ef = wrap;
    end
    if (BTNU) begin
      m_n = 0; m_dp = 4'd0; m_held = 0;
      for (int j = 0; j < 4; j++) m_sh[j] = 4'd0;
    end else begin
      if (wrap) begin
        m_sh[0] = en0; m_sh[1] = en1; m_sh[2] = en2; m_sh[3] = en3; m_dp = dp_en;
      end
      if (!hold) m_held = 0;
      else if (wrap) m_held++;
      m_n++;
    end
    @(posedge clk);
    #1;
    checkOutput("model_an", {28'd0, an}, {28'd0, ea});
    checkOutput("model_seg", {25'd0, seg}, {25'd0, es});
    checkOutput("model_dp", {31'd0, dp}, {31'd0, ed});
    checkOutput("model_frame_done", {31'd0, frame_done}, {31'd0, ef});
  endtask

  task automatic waitFrame();
    int c;
    c = 0;
    step();
    while (frame_done !== 1'b1 && c < 3 * FRAME_LEN) begin
      step();
      c++;
    end
    checkOutput("frame_seen", {31'd0, frame_done}, 32'd1);
  endtask

  initial begin
    int cnt;
    vec_t v;
    for (int j = 0; j < 4; j++) m_sh[j] = 4'd0;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Fields: en3..en0, dp_en, an slot3..0, seg slot3..0, dp slot3..0.
    vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 16'b0111_1011_1101_1110, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{4'h0, 4'h0, 4'h0, 4'h7, 4'b0000, 16'b1111_1111_1111_1110, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1111};
    vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b1111, 16'b1111_1111_1111_1110, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};
    vecs[3] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'b0000, 16'b1111_1011_1101_1110, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b1111};
    vecs[4] = '{4'h0, 4'h5, 4'h0, 4'hC, 4'b0100, 16'b1111_1011_1101_1110, {7'h7F, 7'h12, 7'h40, 7'h3F}, 4'b1011};
    vecs[5] = '{4'h0, 4'h0, 4'h0, 4'hC, 4'b0101, 16'b1111_1111_1111_1110, {7'h7F, 7'h7F, 7'h7F, 7'h3F}, 4'b1110};
    vecs[6] = '{4'hA, 4'h0, 4'h9, 4'h6, 4'b1000, 16'b0111_1011_1101_1110, {7'h3F, 7'h40, 7'h10, 7'h02}, 4'b0111};
    vecs[7] = '{4'h8, 4'h0, 4'h0, 4'h0, 4'b0000, 16'b0111_1011_1101_1110, {7'h00, 7'h40, 7'h40, 7'h40}, 4'b1111};

    // Reset held for three cycles with non-zero inputs.
    BTNU = 1'b1;
    applyStimulus(4'h5, 4'h5, 4'h5, 4'h5, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("reset_an", {28'd0, an}, 32'hF);
      checkOutput("reset_seg", {25'd0, seg}, 32'h7F);
    end
    BTNU = 1'b0;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (frame_done !== 1'b1 && cnt < 3 * FRAME_LEN);
    checkOutput("first_frame_latency", cnt, FRAME_LEN);

    // Frame vectors: inputs captured at the next wrap, then each slot checked.
    foreach (vecs[i]) begin
      v = vecs[i];
      applyStimulus(v.e3, v.e2, v.e1, v.e0, v.dpe, 1'b0);
      waitFrame();
      for (int k = 0; k < 4; k++) begin
        if (k == 0) step();
        else repeat (CLK_DIV) step();
        checkOutput($sformatf("vec%0d_slot%0d_an", i, k), {28'd0, an}, {28'd0, v.an_exp[k*4 +: 4]});
        checkOutput($sformatf("vec%0d_slot%0d_seg", i, k), {25'd0, seg}, {25'd0, v.seg_exp[k*7 +: 7]});
        checkOutput($sformatf("vec%0d_slot%0d_dp", i, k), {31'd0, dp}, {31'd0, v.dp_exp[k]});
      end
    end

    // Mid-frame change must not reach the display until the next snapshot.
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 1'b0);
    waitFrame();
    step();
    step();
    en0 = 4'h8;
    step();
    checkOutput("tear_hold", {25'd0, seg}, 32'h30);
    waitFrame();
    step();
    checkOutput("tear_update", {25'd0, seg}, 32'h00);

    // Blink: two frames dark, two lit, starting after the second held wrap.
    applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 1'b0);
    waitFrame();
    hold = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      waitFrame();
      step();
      checkOutput($sformatf("blink_frame%0d_an", f), {28'd0, an},
                  (f == 2 || f == 3 || f == 6) ? 32'hF : 32'hE);
    end
    hold = 1'b0;
    step();
    checkOutput("drop_hold_lag_an", {28'd0, an}, 32'hF);
    step();
    checkOutput("drop_hold_lit_an", {28'd0, an}, 32'hE);
    checkOutput("drop_hold_lit_seg", {25'd0, seg}, 32'h19);

    // Reset in the middle of a slot.
    BTNU = 1'b1;
    step();
    checkOutput("midslot_reset_an", {28'd0, an}, 32'hF);
    checkOutput("midslot_reset_seg", {25'd0, seg}, 32'h7F);
    checkOutput("midslot_reset_dp", {31'd0, dp}, 32'd1);
    checkOutput("midslot_reset_fd", {31'd0, frame_done}, 32'd0);
    BTNU = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        en0 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        en1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        en2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        en3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp_en = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 199) == 0) hold = ~hold;
      BTNU = ($urandom_range(0, 499) == 0);
      step();
    end
    BTNU = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
